mac_stop_engine: RTL and testbench
==================================

# mac_stop_engine

Sequencer and multiply-accumulate datapath that computes C = A × B over the `mac_stop_mem` matrix store. It sits beside that memory and drives its address, read-enable and write-enable ports. It reads A and B through the memory's combinational read path, accumulates dot products, and writes each finished C element back. A host starts a run with a start/done handshake and can abort it at any time with `stop`.

## Interface
- `M`, 4: rows of A and C.
- `K`, 4: columns of A and rows of B (dot-product length).
- `N`, 4: columns of B and C.
- `DATA_WIDTH_INIT_MATRIX`, 32: width of A and B elements.
- `DATA_WIDTH_RESULT_MATRIX`, 2*DATA_WIDTH_INIT_MATRIX+$clog2(K): width of C elements and of the accumulator.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `stop`  in  1  abort the current run.
- `busy`  out  1  high in MAC and WRITE.
- `done`  out  1  one-cycle pulse when a run completes.
- `row_addr_a` / `col_addr_a`  out  $clog2(M) / $clog2(K)  A address.
- `row_addr_b` / `col_addr_b`  out  $clog2(K) / $clog2(N)  B address.
- `row_addr_c` / `col_addr_c`  out  $clog2(M) / $clog2(N)  C address.
- `matrix_a_re`, `matrix_b_re`, `matrix_c_we`  out  1 each  memory strobes.
- `mem_data_a`, `mem_data_b`  in  DATA_WIDTH_INIT_MATRIX  memory read data, valid in the same cycle as the address.
- `wr_data_c`  out  DATA_WIDTH_RESULT_MATRIX  C write data.

## Operation
- Loop indices: i over 0..M-1 (outer), j over 0..N-1, k over 0..K-1 (inner).
- FSM states: IDLE, MAC, WRITE, DONE.
- IDLE:
  - If `start`=1 and `stop`=0, go to MAC and clear i, j, k.
  - All strobes are 0.
- MAC:
  - `matrix_a_re`=`matrix_b_re`=1; A address = (i,k); B address = (k,j).
  - acc <= (k==0 ? 0 : acc) + mem_data_a*mem_data_b.
  - When k==K-1, clear k and go to WRITE; otherwise k++.
- WRITE:
  - `matrix_c_we`=1; C address = (i,j); `wr_data_c`=acc.
  - If i==M-1 and j==N-1, go to DONE.
  - Otherwise advance j; when j wraps, clear j, advance i; then return to MAC.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `stop`=1 in MAC, WRITE or DONE:
  - Next state is IDLE; no `done` pulse.
  - `stop` overrides the transition out of DONE, so `done` never pulses after a stop in DONE.
  - `stop` overrides a write in the same cycle: `matrix_c_we` is gated to 0, so a partial element is never written.
  - Elements already written stay in memory.
- `start` during MAC, WRITE or DONE is ignored (no queueing).
- Arithmetic:
  - Product is 2*DATA_WIDTH_INIT_MATRIX bits, zero-extended into the accumulator.
  - The accumulator cannot overflow for any operand values.
- Address outputs are 0 whenever their strobe is 0.

## Timing
- Reset (`reset`=1 at an edge), from any state:
  - State goes to IDLE; i, j, k and acc go to 0.
  - `busy`, `done`, all strobes, all addresses and `wr_data_c` are 0 from the next cycle.
- A run is M*N*(K+1) busy cycles followed by one DONE cycle. With defaults: 80 busy cycles; `done` is high in cycle 81 after the start edge.
- Element C[i][j] is written in busy cycle (i*N+j)*(K+1)+K (0-based).
- The memory read path is combinational, so there are no wait states.
- `busy` falls in the same cycle that `done` rises.

## Configuration
- `MAC_STOP_SIGNED_EN` defined:
  - A and B are two's-complement.
  - Each product is signed and sign-extended into the accumulator.
  - `wr_data_c` is a two's-complement value.
- `MAC_STOP_SIGNED_EN` undefined: all arithmetic is unsigned, as described above.

## Structure
- Package `mac_stop_pkg` holds:
  - the state enum `mac_stop_state_t` (IDLE, MAC, WRITE, DONE);
  - the result-width helper function shared with `mac_stop_mem`.
- Sub-module `mac_stop_pe` holds the multiplier and accumulator. Its ports are clear/enable, two operands and the accumulated result.
- Top level holds the FSM and the index counters.

## Test plan
- Identity test: A = I, B[r][c]=r*4+c, then start. Expected: memory C equals B; `done` pulses once in cycle 81; exactly 16 `matrix_c_we` pulses.
- Maximum operands: all A and B elements = 0xFFFFFFFF. Expected: every C element = 0x3_FFFF_FFF8_0000_0004, with no truncation.
- Stop in a WRITE cycle: assert `stop` in busy cycle 9 (the write of C[0][1]). Expected: C[0][0] written; C[0][1] not written; IDLE next cycle; no `done` pulse.
- Ignored start: pulse `start` again at cycle 30 of a run. Expected: completion timing unchanged; one `done` pulse.
- Reset mid-run: assert `reset` at cycle 40. Expected: all outputs 0 next cycle; a later `start` runs a full 80-cycle computation correctly.
- Signed build (`MAC_STOP_SIGNED_EN` defined): all A = 0xFFFFFFFF (-1), all B = 1. Expected: every C element = -4 in two's complement.

Source files
------------

// File: rtl/mac_stop_pkg.sv
// rtl/mac_stop_pkg.sv - shared types and width helper for the mac_stop matrix engine
// Contents:
//   mac_stop_state_t      : sequencer states (IDLE, MAC, WRITE, DONE)
//   mac_stop_result_width : C element / accumulator width, shared with mac_stop_mem
package mac_stop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mac_stop_state_t;

  // Wide enough that K full-scale products can be summed without overflow.
  function automatic int mac_stop_result_width(input int data_width, input int k_dim);
    return 2 * data_width + $clog2(k_dim);
  endfunction

endpackage

// File: rtl/mac_stop_engine_if.sv
// rtl/mac_stop_engine_if.sv - host handshake and matrix-memory bus of the mac_stop engine
// Signals:
//   start/stop (host -> engine), busy/done (engine -> host)
//   row/col_addr_a/b/c, matrix_a_re/b_re/c_we, wr_data_c (engine -> memory)
//   mem_data_a/b (memory -> engine, combinational read data)
// Modports: master = engine side, slave = host/memory side.
interface mac_stop_engine_if
  import mac_stop_pkg::*;
#(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = mac_stop_result_width(DATA_WIDTH_INIT_MATRIX, K)
) ();

  localparam int MW = $clog2(M);
  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);

  logic                                start;
  logic                                stop;
  logic                                busy;
  logic                                done;
  logic [MW-1:0]                       row_addr_a;
  logic [KW-1:0]                       col_addr_a;
  logic [KW-1:0]                       row_addr_b;
  logic [NW-1:0]                       col_addr_b;
  logic [MW-1:0]                       row_addr_c;
  logic [NW-1:0]                       col_addr_c;
  logic                                matrix_a_re;
  logic                                matrix_b_re;
  logic                                matrix_c_we;
  logic [DATA_WIDTH_INIT_MATRIX-1:0]   mem_data_a;
  logic [DATA_WIDTH_INIT_MATRIX-1:0]   mem_data_b;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] wr_data_c;

  modport master (
    input  start, stop, mem_data_a, mem_data_b,
    output busy, done,
    output row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c,
    output matrix_a_re, matrix_b_re, matrix_c_we, wr_data_c
  );

  modport slave (
    output start, stop, mem_data_a, mem_data_b,
    input  busy, done,
    input  row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c,
    input  matrix_a_re, matrix_b_re, matrix_c_we, wr_data_c
  );

endinterface

// File: rtl/mac_stop_pe.sv
// rtl/mac_stop_pe.sv - multiplier and accumulator for one C element
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : start a new dot product (accumulate onto zero instead of acc)
//   en         : accumulate op_a*op_b this cycle
//   op_a, op_b : operands from the A and B read ports
//   acc        : running dot product
// Build option MAC_STOP_SIGNED_EN: operands and product are two's-complement.
module mac_stop_pe #(
  parameter int DW = 32,
  parameter int RW = 66
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic [RW-1:0] acc
);

  logic [2*DW-1:0] op_a_ext;
  logic [2*DW-1:0] op_b_ext;
  logic [2*DW-1:0] prod;
  logic [RW-1:0]   prod_ext;

  // Operands are widened to the full product width first; the low 2*DW bits
  // of that multiply are the exact product in both signed and unsigned builds.
`ifdef MAC_STOP_SIGNED_EN
  assign op_a_ext = {{DW{op_a[DW-1]}}, op_a};
  assign op_b_ext = {{DW{op_b[DW-1]}}, op_b};
  assign prod     = op_a_ext * op_b_ext;
  assign prod_ext = {{(RW-2*DW){prod[2*DW-1]}}, prod};
`else
  assign op_a_ext = {{DW{1'b0}}, op_a};
  assign op_b_ext = {{DW{1'b0}}, op_b};
  assign prod     = op_a_ext * op_b_ext;
  assign prod_ext = {{(RW-2*DW){1'b0}}, prod};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr ? '0 : acc) + prod_ext;
    end
  end

endmodule

// File: rtl/mac_stop_engine.sv
// rtl/mac_stop_engine.sv - sequencer computing C = A x B over the mac_stop_mem store
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mac_stop_engine_if.master (start/stop/busy/done, memory addresses,
//           strobes, read data and C write data)
// Build option MAC_STOP_SIGNED_EN: signed A/B/C arithmetic (see mac_stop_pe).
module mac_stop_engine
  import mac_stop_pkg::*;
#(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = mac_stop_result_width(DATA_WIDTH_INIT_MATRIX, K)
) (
  input  logic              clk,
  input  logic              reset,
  mac_stop_engine_if.master bus
);

  localparam int MW = $clog2(M);
  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);
  localparam int DW = DATA_WIDTH_INIT_MATRIX;
  localparam int RW = DATA_WIDTH_RESULT_MATRIX;

  localparam logic [MW-1:0] I_LAST = MW'(M - 1);
  localparam logic [NW-1:0] J_LAST = NW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  mac_stop_state_t state;
  logic [MW-1:0]   i_idx;
  logic [NW-1:0]   j_idx;
  logic [KW-1:0]   k_idx;
  logic            busy_q;
  logic            done_q;
  logic            re_q;
  logic            we_q;
  logic            c_we;
  logic [RW-1:0]   acc;

  // Output flags are registered alongside the state so each one is valid for
  // the whole cycle the state is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      i_idx  <= '0;
      j_idx  <= '0;
      k_idx  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      re_q   <= 1'b0;
      we_q   <= 1'b0;
    end else if (state != IDLE && bus.stop) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      re_q   <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state  <= MAC;
            i_idx  <= '0;
            j_idx  <= '0;
            k_idx  <= '0;
            busy_q <= 1'b1;
            re_q   <= 1'b1;
          end
        end
        MAC: begin
          if (k_idx == K_LAST) begin
            k_idx <= '0;
            state <= WRITE;
            re_q  <= 1'b0;
            we_q  <= 1'b1;
          end else begin
            k_idx <= k_idx + 1'b1;
          end
        end
        WRITE: begin
          we_q <= 1'b0;
          if (i_idx == I_LAST && j_idx == J_LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            if (j_idx == J_LAST) begin
              j_idx <= '0;
              i_idx <= i_idx + 1'b1;
            end else begin
              j_idx <= j_idx + 1'b1;
            end
            state <= MAC;
            re_q  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          re_q   <= 1'b0;
          we_q   <= 1'b0;
        end
      endcase
    end
  end

  mac_stop_pe #(
    .DW (DW),
    .RW (RW)
  ) u_pe (
    .clk   (clk),
    .reset (reset),
    .clr   (k_idx == '0),
    .en    (state == MAC),
    .op_a  (bus.mem_data_a),
    .op_b  (bus.mem_data_b),
    .acc   (acc)
  );

  // stop in the same cycle suppresses the write and the done pulse, so an
  // aborted run never commits a partial element or reports completion.
  assign c_we = we_q & ~bus.stop;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q & ~bus.stop;
  assign bus.matrix_a_re = re_q;
  assign bus.matrix_b_re = re_q;
  assign bus.matrix_c_we = c_we;

  assign bus.row_addr_a = re_q ? i_idx : '0;
  assign bus.col_addr_a = re_q ? k_idx : '0;
  assign bus.row_addr_b = re_q ? k_idx : '0;
  assign bus.col_addr_b = re_q ? j_idx : '0;
  assign bus.row_addr_c = c_we ? i_idx : '0;
  assign bus.col_addr_c = c_we ? j_idx : '0;
  assign bus.wr_data_c  = c_we ? acc : '0;

endmodule

// File: tb/tb_mac_stop_engine.sv
// tb/tb_mac_stop_engine.sv - randomized self-checking bench for mac_stop_engine
module tb_mac_stop_engine;

  localparam int RW = 66;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_stop_engine_if #(.M(4), .K(4), .N(4), .DATA_WIDTH_INIT_MATRIX(32),
                       .DATA_WIDTH_RESULT_MATRIX(RW)) bus ();

  mac_stop_engine #(.M(4), .K(4), .N(4), .DATA_WIDTH_INIT_MATRIX(32),
                    .DATA_WIDTH_RESULT_MATRIX(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [31:0]   mat_a [4][4];
  logic [31:0]   mat_b [4][4];
  logic [RW-1:0] mem_c [4][4];
  bit            c_written [4][4];

  always_comb begin
    bus.mem_data_a = mat_a[bus.row_addr_a][bus.col_addr_a];
    bus.mem_data_b = mat_b[bus.row_addr_b][bus.col_addr_b];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Dot product straight from the matrix definition.
  function automatic logic [RW-1:0] ref_elem(input int r, input int c);
    logic [RW-1:0] sum;
    sum = '0;
    for (int kk = 0; kk < 4; kk++) begin
`ifdef MAC_STOP_SIGNED_EN
      sum += RW'(longint'(int'(mat_a[r][kk])) * longint'(int'(mat_b[kk][c])));
`else
      sum += RW'(64'(mat_a[r][kk]) * 64'(mat_b[kk][c]));
`endif
    end
    return sum;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, RW'(bus.busy), '0);
    check_eq({tag, "_done"}, RW'(bus.done), '0);
    check_eq({tag, "_strobes"}, RW'({bus.matrix_a_re, bus.matrix_b_re, bus.matrix_c_we}), '0);
    check_eq({tag, "_addrs"}, RW'({bus.row_addr_a, bus.col_addr_a, bus.row_addr_b,
                                   bus.col_addr_b, bus.row_addr_c, bus.col_addr_c}), '0);
    check_eq({tag, "_wr_data"}, bus.wr_data_c, '0);
  endtask

  int done_cyc, n_done, n_we;

  // One run from a start edge; n counts cycles after that edge (busy cycle b is n=b+1).
  task automatic do_run(input int stop_n, input int restart_n, input int rst_n);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_c[r][c]     = '1;
        c_written[r][c] = 1'b0;
      end
    done_cyc = 0; n_done = 0; n_we = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      bus.stop  = (n == stop_n);
      bus.start = (n == restart_n);
      reset     = (n == rst_n);
      #1;
      if (bus.matrix_c_we) begin
        mem_c[bus.row_addr_c][bus.col_addr_c]     = bus.wr_data_c;
        c_written[bus.row_addr_c][bus.col_addr_c] = 1'b1;
        n_we++;
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (stop_n > 0 && n == stop_n + 1) check_eq("stop_to_idle_busy", RW'(bus.busy), '0);
      if (rst_n > 0 && n == rst_n + 1) check_outputs_zero("reset_mid_run");
    end
    @(negedge clk);
    bus.stop = 1'b0; bus.start = 1'b0; reset = 1'b0;
  endtask

  task automatic check_full_run(input string tag);
    check_eq({tag, "_done_cycle"}, RW'(done_cyc), RW'(81));
    check_eq({tag, "_done_count"}, RW'(n_done), RW'(1));
    check_eq({tag, "_we_count"}, RW'(n_we), RW'(16));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check_eq($sformatf("%s_c%0d%0d", tag, r, c), mem_c[r][c], ref_elem(r, c));
  endtask

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r][c] = $urandom;
        mat_b[r][c] = $urandom;
      end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r][c] = '0;
        mat_b[r][c] = '0;
      end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check_outputs_zero("reset_state");

    // Identity: C must equal B.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r][c] = (r == c) ? 32'd1 : 32'd0;
        mat_b[r][c] = 32'(r * 4 + c);
      end
    do_run(0, 0, 0);
    check_full_run("identity");
    check_eq("identity_c23_is_b", mem_c[2][3], RW'(11));

    // Full-scale operands.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r][c] = 32'hFFFF_FFFF;
        mat_b[r][c] = 32'hFFFF_FFFF;
      end
    do_run(0, 0, 0);
    check_full_run("max_ops");
`ifndef MAC_STOP_SIGNED_EN
    check_eq("max_ops_const", mem_c[3][3], 66'h3_FFFF_FFF8_0000_0004);
`else
    check_eq("max_ops_const", mem_c[3][3], 66'd4);
`endif

    // Random matrices.
    for (int t = 0; t < 3; t++) begin
      fill_random();
      do_run(0, 0, 0);
      check_full_run($sformatf("rand%0d", t));
    end

    // Stop during the write of C[0][1].
    fill_random();
    do_run(10, 0, 0);
    check_eq("stop_c00_written", RW'(c_written[0][0]), RW'(1));
    check_eq("stop_c00_value", mem_c[0][0], ref_elem(0, 0));
    check_eq("stop_c01_not_written", RW'(c_written[0][1]), '0);
    check_eq("stop_we_count", RW'(n_we), RW'(1));
    check_eq("stop_no_done", RW'(n_done), '0);

    // Extra start mid-run is ignored.
    fill_random();
    do_run(0, 30, 0);
    check_full_run("restart_ignored");

    // Reset mid-run, then a clean full run.
    fill_random();
    do_run(0, 0, 40);
    check_eq("reset_run_no_done", RW'(n_done), '0);
    do_run(0, 0, 0);
    check_full_run("after_reset");

`ifdef MAC_STOP_SIGNED_EN
    // -1 * 1 summed four times.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r][c] = 32'hFFFF_FFFF;
        mat_b[r][c] = 32'd1;
      end
    do_run(0, 0, 0);
    check_full_run("signed_neg");
    check_eq("signed_neg_const", mem_c[1][2], 66'h3_FFFF_FFFF_FFFF_FFFC);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
